// File: rtl/dram_axi_dma_master_pkg.sv
// dram_axi_dma_master_pkg: shared FSM encoding and AXI constants for the DRAM DMA master
package dram_axi_dma_master_pkg;
  typedef enum logic [2:0] {
    IDLE,
    WR_FETCH,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RD_PUSH,
    FINISH
  } state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int WORD_SHIFT = 3;
endpackage

// File: rtl/axi_lite_wr_channel.sv
// axi_lite_wr_channel: issues paired AW/W valids together and retires each on its own handshake
module axi_lite_wr_channel (
  input  logic aclk,
  input  logic aresetn,
  input  logic start,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic complete
);
  logic awvalid_d, awvalid_q, wvalid_d, wvalid_q;
  always_comb begin
    awvalid_d = start | (awvalid_q & ~awready);
    wvalid_d = start | (wvalid_q & ~wready);
    complete = (awvalid_q | wvalid_q) & ~(awvalid_q & ~awready) & ~(wvalid_q & ~wready);
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
    end
  end
  assign awvalid = awvalid_q;
  assign wvalid = wvalid_q;
endmodule

// File: rtl/dram_axi_dma_master.sv
// dram_axi_dma_master: AXI4-Lite master moving words between command/stream ports and the DRAM slave
module dram_axi_dma_master
  import dram_axi_dma_master_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_ADDR_WIDTH = 11,
  parameter int WORD_IDX_W = 8,
  parameter int LEN_W = 9
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_dir,
  input  logic [WORD_IDX_W-1:0]           cmd_addr,
  input  logic [LEN_W-1:0]                cmd_len,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  state_t state_d, state_q;
  logic [WORD_IDX_W-1:0] idx_d, idx_q;
  logic [LEN_W-1:0] rem_d, rem_q;
  logic err_d, err_q, wr_start, wr_complete;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_d, wdata_q, mdata_d, mdata_q;
  logic [WORD_IDX_W+WORD_SHIFT-1:0] byte_addr;
  axi_lite_wr_channel u_wr (
    .aclk(S_AXI_ACLK),
    .aresetn(S_AXI_ARESETN),
    .start(wr_start),
    .awready(M_AXI_AWREADY),
    .wready(M_AXI_WREADY),
    .awvalid(M_AXI_AWVALID),
    .wvalid(M_AXI_WVALID),
    .complete(wr_complete)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    rem_d = rem_q;
    err_d = err_q;
    wdata_d = wdata_q;
    mdata_d = mdata_q;
    wr_start = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        idx_d = cmd_addr;
        rem_d = cmd_len;
        err_d = 1'b0;
        state_d = (cmd_len == '0) ? FINISH : cmd_dir ? RD_ADDR : WR_FETCH;
      end
      WR_FETCH: if (s_valid) begin
        wdata_d = s_data;
        wr_start = 1'b1;
        state_d = WR_ADDR;
      end
      WR_ADDR: state_d = wr_complete ? WR_RESP : WR_ADDR;
      WR_RESP: if (M_AXI_BVALID) begin
        err_d = err_q | (M_AXI_BRESP != RESP_OKAY);
        rem_d = rem_q - LEN_W'(1);
        idx_d = idx_q + WORD_IDX_W'(1);
        state_d = (rem_q == LEN_W'(1)) ? FINISH : WR_FETCH;
      end
      RD_ADDR: state_d = M_AXI_ARREADY ? RD_DATA : RD_ADDR;
      RD_DATA: if (M_AXI_RVALID) begin
        mdata_d = M_AXI_RDATA;
        err_d = err_q | (M_AXI_RRESP != RESP_OKAY);
        state_d = RD_PUSH;
      end
      RD_PUSH: if (m_ready) begin
        rem_d = rem_q - LEN_W'(1);
        idx_d = idx_q + WORD_IDX_W'(1);
        state_d = (rem_q == LEN_W'(1)) ? FINISH : RD_ADDR;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
      idx_q <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
      wdata_q <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rem_q <= rem_d;
      err_q <= err_d;
      wdata_q <= wdata_d;
      mdata_q <= mdata_d;
    end
  end
  assign byte_addr = {idx_q, {WORD_SHIFT{1'b0}}};
  assign M_AXI_AWADDR = C_M_AXI_ADDR_WIDTH'(byte_addr);
  assign M_AXI_ARADDR = C_M_AXI_ADDR_WIDTH'(byte_addr);
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB = '1;
  assign M_AXI_WDATA = wdata_q;
  assign M_AXI_BREADY = state_q == WR_RESP;
  assign M_AXI_ARVALID = state_q == RD_ADDR;
  assign M_AXI_RREADY = state_q == RD_DATA;
  assign cmd_ready = state_q == IDLE;
  assign s_ready = state_q == WR_FETCH;
  assign m_valid = state_q == RD_PUSH;
  assign m_data = mdata_q;
  assign busy = state_q != IDLE;
  assign done = state_q == FINISH;
  assign err = err_q;
endmodule
